imem_arbiter: RTL and testbench

- Shares one single-ported synchronous instruction memory between two requesters:
  - the pipeline fetch stage, which only reads;
  - the program loader / debug port, which reads and writes.
- Sits between the IF stage and the instruction RAM.
- Issues at most one access per cycle. Read data is returned one cycle after issue.
- Generates the fetch stall and supports a loader lock that holds the CPU off memory during boot.

---
 rtl/imem_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// imem_arbiter : shares one single-ported sync instruction RAM between the
//                fetch stage and the loader/debug port (optional IMEM_ARB_PERF_EN)
// Revision     : 1.0
// ============================================================================
module imem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int MEM_AW        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef IMEM_ARB_PERF_EN
  output logic [31:0]              stall_cnt,
`endif
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  input  logic                     if_flush,
  output logic [INSTR_WIDTH-1:0]   if_instr,
  output logic                     if_valid,
  output logic                     if_misaligned,
  output logic                     stall_f,
  input  logic                     ld_req,
  input  logic                     ld_we,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [INSTR_WIDTH-1:0]   ld_wdata,
  input  logic                     ld_lock,
  output logic                     ld_gnt,
  output logic                     ld_ack,
  output logic [INSTR_WIDTH-1:0]   ld_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [INSTR_WIDTH-1:0]   mem_wdata,
  input  logic [INSTR_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    PEND_NONE    = 2'd0,
    PEND_FETCH   = 2'd1,
    PEND_LOAD_RD = 2'd2,
    PEND_LOAD_WR = 2'd3
  } pend_e;

  typedef enum logic {
    WIN_FETCH = 1'b0,
    WIN_LOAD  = 1'b1
  } win_e;

  pend_e                  pend_q, pend_d;
  win_e                   win_q, win_d;
  logic [INSTR_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  logic w_fetch_ok;
  logic w_grant_fetch;
  logic w_grant_ld;

  // Upper address bits beyond the RAM depth and the loader byte offset are ignored.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{if_addr[ADDRESS_WIDTH-1:MEM_AW+2],
                                ld_addr[ADDRESS_WIDTH-1:MEM_AW+2],
                                ld_addr[1:0]};

  assign if_misaligned = if_req & (if_addr[1:0] != 2'b00);
  assign w_fetch_ok    = if_req & ~if_misaligned & ~ld_lock;

  // On a tie the port that did not win last time gets the memory.
  assign w_grant_fetch = ~rst & w_fetch_ok & (~ld_req | (win_q == WIN_LOAD));
  assign w_grant_ld    = ~rst & ld_req & (~w_fetch_ok | (win_q == WIN_FETCH));

  assign stall_f   = ~rst & if_req & ~if_misaligned & ~w_grant_fetch;
  assign ld_gnt    = w_grant_ld;
  assign mem_en    = w_grant_fetch | w_grant_ld;
  assign mem_we    = w_grant_ld & ld_we;
  assign mem_addr  = w_grant_ld ? ld_addr[MEM_AW+1:2] : if_addr[MEM_AW+1:2];
  assign mem_wdata = w_grant_ld ? ld_wdata : '0;

  assign if_valid = (pend_q == PEND_FETCH) & ~if_flush;
  assign if_instr = if_valid ? mem_rdata : '0;
  assign ld_ack   = (pend_q == PEND_LOAD_RD) | (pend_q == PEND_LOAD_WR);
  assign ld_rdata = (pend_q == PEND_LOAD_RD) ? mem_rdata : ld_rdata_q;

  always_comb begin
    pend_d     = PEND_NONE;
    win_d      = win_q;
    ld_rdata_d = ld_rdata;
    if (w_grant_ld) begin
      pend_d = ld_we ? PEND_LOAD_WR : PEND_LOAD_RD;
      win_d  = WIN_LOAD;
    end else if (w_grant_fetch) begin
      // A flushed fetch still occupies the RAM but its response is never presented.
      pend_d = if_flush ? PEND_NONE : PEND_FETCH;
      win_d  = WIN_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= PEND_NONE;
      win_q      <= WIN_LOAD;
      ld_rdata_q <= '0;
    end else begin
      pend_q     <= pend_d;
      win_q      <= win_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_imem_arbiter : directed vector bench for imem_arbiter with a RAM model
// Revision        : 1.0
// ============================================================================
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_misaligned;
  logic        stall_f;
  logic        ld_req = 1'b0;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_lock = 1'b0;
  logic        ld_gnt;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  imem_arbiter #(
    .ADDRESS_WIDTH(32),
    .INSTR_WIDTH  (32),
    .MEM_AW       (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .if_misaligned(if_misaligned),
    .stall_f      (stall_f),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_lock      (ld_lock),
    .ld_gnt       (ld_gnt),
    .ld_ack       (ld_ack),
    .ld_rdata     (ld_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-ported synchronous RAM, read data one cycle after issue.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic        e_stall;
    logic        e_mis;
    logic        e_en;
    logic        e_we;
    logic [9:0]  e_addr;
    logic        e_gnt;
    logic        e_ack;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ifr, input logic [31:0] ifa, input logic fl,
    input logic ldr, input logic we, input logic [31:0] lda, input logic [31:0] wd,
    input logic lock, input logic es, input logic em, input logic een, input logic ewe,
    input logic [9:0] ea, input logic eg, input logic eack, input logic ev,
    input logic [31:0] ei, input logic [31:0] er);
    vec_t v;
    v.rst = r; v.if_req = ifr; v.if_addr = ifa; v.if_flush = fl;
    v.ld_req = ldr; v.ld_we = we; v.ld_addr = lda; v.ld_wdata = wd; v.ld_lock = lock;
    v.e_stall = es; v.e_mis = em; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
    v.e_gnt = eg; v.e_ack = eack; v.e_valid = ev; v.e_instr = ei; v.e_rdata = er;
    return v;
  endfunction

  vec_t vecs [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [80:0] act;
    logic [80:0] exp;
    int          k;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    //       rst ifr ifa    fl ldr we lda    wdata          lk | st mi en we addr   gnt ack val instr          rdata
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h0));
    // fetch-only stream
    vecs.push_back(mk(0, 1, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h0,  0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h4,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h1,  0, 0, 1, 32'h11,       32'h0));
    vecs.push_back(mk(0, 1, 32'h8,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h2,  0, 0, 1, 32'h22,       32'h0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 1, 32'h33,       32'h0));
    // loader write then fetch readback
    vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 1, 1, 10'h10, 1, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h10, 0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 1, 32'hDEADBEEF, 32'h0));
    // contention from reset: F, L, F, L
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h4,  0, 1, 0, 32'h8, 32'h0,        0,  0, 0, 1, 0, 10'h1,  0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h4,  0, 1, 0, 32'h8, 32'h0,        0,  1, 0, 1, 0, 10'h2,  1, 0, 1, 32'h22,       32'h0));
    vecs.push_back(mk(0, 1, 32'h4,  0, 1, 0, 32'h8, 32'h0,        0,  0, 0, 1, 0, 10'h1,  0, 1, 0, 32'h0,        32'h33));
    vecs.push_back(mk(0, 1, 32'h4,  0, 1, 0, 32'h8, 32'h0,        0,  1, 0, 1, 0, 10'h2,  1, 0, 1, 32'h22,       32'h33));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 1, 0, 32'h0,        32'h33));
    // lock holds fetch off; loader still served
    vecs.push_back(mk(0, 1, 32'h0,  0, 0, 0, 32'h0, 32'h0,        1,  1, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h33));
    vecs.push_back(mk(0, 1, 32'h0,  0, 1, 0, 32'hC, 32'h0,        1,  1, 0, 1, 0, 10'h3,  1, 0, 0, 32'h0,        32'h33));
    vecs.push_back(mk(0, 1, 32'h0,  0, 0, 0, 32'h0, 32'h0,        1,  1, 0, 0, 0, 10'h0,  0, 1, 0, 32'h0,        32'h44));
    // flush in issue cycle, then flush in response cycle
    vecs.push_back(mk(0, 1, 32'h0,  1, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h0,  0, 0, 0, 32'h0,        32'h44));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h44));
    vecs.push_back(mk(0, 1, 32'h4,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 1, 0, 10'h1,  0, 0, 0, 32'h0,        32'h44));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h44));
    // misaligned fetch
    vecs.push_back(mk(0, 1, 32'h6,  0, 0, 0, 32'h0, 32'h0,        0,  0, 1, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h44));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h44));
    // reset the cycle after a loader read grant
    vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 32'h8, 32'h0,        0,  0, 0, 1, 0, 10'h2,  1, 0, 0, 32'h0,        32'h44));
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0,        0,  0, 0, 0, 0, 10'h0,  0, 0, 0, 32'h0,        32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      if_flush = vecs[i].if_flush; ld_req = vecs[i].ld_req; ld_we = vecs[i].ld_we;
      ld_addr = vecs[i].ld_addr; ld_wdata = vecs[i].ld_wdata; ld_lock = vecs[i].ld_lock;
      #1;
      // mem_addr is only meaningful with mem_en, if_instr only with if_valid
      act = {stall_f, if_misaligned, mem_en, mem_we,
             (vecs[i].e_en ? mem_addr : 10'h0), ld_gnt, ld_ack, if_valid,
             (vecs[i].e_valid ? if_instr : 32'h0), ld_rdata};
      exp = {vecs[i].e_stall, vecs[i].e_mis, vecs[i].e_en, vecs[i].e_we,
             vecs[i].e_addr, vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_valid,
             vecs[i].e_instr, vecs[i].e_rdata};
      check($sformatf("vec%0d", i), {47'h0, act}, {47'h0, exp});
    end

    // Loader writes under lock, then the released fetch reads the word back.
    @(negedge clk);
    ld_lock = 1; if_req = 1; if_addr = 32'h80;
    ld_req = 1; ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'hCAFEF00D;
    #1;
    check("lock_write_gnt", {126'h0, ld_gnt, stall_f}, {126'h0, 1'b1, 1'b1});
    @(negedge clk);
    ld_req = 0;
    #1;
    check("lock_write_ack", {126'h0, ld_ack, stall_f}, {126'h0, 1'b1, 1'b1});
    @(negedge clk);
    ld_lock = 0;
    #1;
    check("unlock_fetch_gnt", {126'h0, stall_f, mem_en}, {126'h0, 1'b0, 1'b1});
    @(negedge clk);
    if_req = 0;
    k = 0;
    #1;
    while (!if_valid && k < 4) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!if_valid) begin
      checks++;
      errors++;
      $display("FAIL readback_timeout: got if_valid=0 expected if_valid=1 within 4 cycles");
    end else begin
      check("readback_instr", {96'h0, if_instr}, {96'h0, 32'hCAFEF00D});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
